// File: rtl/bcd_div_judge_pkg.sv
// Shared types and constants for the BCD divisibility-game judge.
package bcd_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_PLAY,
        ST_SCORE,
        ST_REPORT
    } state_t;

    localparam int unsigned MAX_TESTS = 6;

    // Entry i is the divisor checked by test bit i.
    localparam logic [MAX_TESTS-1:0][3:0] DIV = {4'd9, 4'd5, 4'd11, 4'd7, 4'd3, 4'd2};

    function automatic logic [2:0] popcount(input logic [MAX_TESTS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_TESTS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_div_judge_if.sv
// Game-side bus of the divisibility judge: operand, player controls and score outputs.
interface bcd_div_judge_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned NUM_TESTS  = 4,
    parameter int unsigned SCORE_W    = 7
);

    logic [4*NUM_DIGITS-1:0] Digits_In;
    logic                    Game_Start;
    logic                    Load_Input;
    logic                    Timeout;
    logic [NUM_TESTS-1:0]    Player_Input;
    logic                    Partial_Mode;
    logic [SCORE_W-1:0]      Score;
    logic [SCORE_W-1:0]      Rounds;
    logic [NUM_TESTS-1:0]    LEDs;
    logic                    Score_Req;
    logic                    Busy;
    logic                    Bcd_Err;

    modport master (
        output Digits_In, Game_Start, Load_Input, Timeout, Player_Input, Partial_Mode,
        input  Score, Rounds, LEDs, Score_Req, Busy, Bcd_Err
    );

    modport slave (
        input  Digits_In, Game_Start, Load_Input, Timeout, Player_Input, Partial_Mode,
        output Score, Rounds, LEDs, Score_Req, Busy, Bcd_Err
    );

endinterface

// File: rtl/bcd_div_judge_mod_step.sv
// One Horner residue stepper: r <= (r*10 + d) mod DIVISOR, one digit per enabled cycle.
module bcd_mod_step #(
    parameter logic [3:0] DIVISOR = 4'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [3:0] digit_i,
    output logic [3:0] nxt_o
);

    logic [3:0] res_q, res_d;
    logic [6:0] acc;
    logic [6:0] rem;

    // nxt_o is the post-step residue so the caller can judge on the final digit's edge.
    always_comb begin
        acc   = {3'b000, res_q} * 7'd10 + {3'b000, digit_i};
        rem   = acc % {3'b000, DIVISOR};
        nxt_o = rem[3:0];
        res_d = res_q;
        if (clr_i) begin
            res_d = '0;
        end else if (en_i) begin
            res_d = nxt_o;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

endmodule

// File: rtl/bcd_div_judge.sv
// Divisibility-game judge: snapshots a BCD operand, evaluates divisor tests serially and scores guesses.
module bcd_div_judge
    import bcd_game_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned NUM_TESTS  = 4,
    parameter int unsigned SCORE_W    = 7
) (
    input logic            clk,
    input logic            reset,
    bcd_div_judge_if.slave bus
);

    localparam int unsigned     OP_W     = 4 * NUM_DIGITS;
    localparam int unsigned     IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t               state_q, state_d;
    logic [OP_W-1:0]      shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   rounds_q, rounds_d;
    logic [NUM_TESTS-1:0] leds_q, leds_d;
    logic [NUM_TESTS-1:0] result_q, result_d;
    logic [NUM_TESTS-1:0] guess_q, guess_d;
    logic                 bcd_err_q, bcd_err_d;
    logic                 req_q, req_d;
    logic                 busy_q, busy_d;

    logic                 capture;
    logic                 step_en;
    logic [3:0]           digit;
    logic [3:0]           nxt [NUM_TESTS];
    logic [NUM_TESTS-1:0] hit;
    logic                 bad_digit;
    logic [MAX_TESTS-1:0] agree;
    logic [2:0]           inc;
    logic [SCORE_W:0]     sum;

    assign digit = shift_q[OP_W-1 -: 4];

    for (genvar g = 0; g < NUM_TESTS; g++) begin : g_step
        bcd_mod_step #(.DIVISOR(DIV[g])) u_step (
            .clk     (clk),
            .reset   (reset),
            .clr_i   (capture),
            .en_i    (step_en),
            .digit_i (digit),
            .nxt_o   (nxt[g])
        );
    end

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_TESTS; i++) begin
            hit[i] = (nxt[i] == 4'd0);
        end
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bus.Digits_In[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
        agree                 = '0;
        agree[NUM_TESTS-1:0]  = ~(guess_q ^ result_q);
        inc = bus.Partial_Mode ? popcount(agree) : {2'b00, (guess_q == result_q)};
        // One spare bit catches the carry before saturating.
        sum = {1'b0, score_q} + (SCORE_W + 1)'(inc);
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        score_d   = score_q;
        rounds_d  = rounds_q;
        leds_d    = leds_q;
        result_d  = result_q;
        guess_d   = guess_q;
        bcd_err_d = bcd_err_q;
        capture   = 1'b0;
        step_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                score_d  = '0;
                rounds_d = '0;
                leds_d   = '0;
                result_d = '0;
                if (bus.Game_Start) begin
                    capture = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                step_en = 1'b1;
                shift_d = shift_q << 4;
                idx_d   = idx_q + IDX_W'(1);
                if (!bus.Timeout) begin
                    state_d = ST_REPORT;
                end else if (idx_q == LAST_IDX) begin
                    result_d = bcd_err_q ? '0 : hit;
                    state_d  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (bus.Load_Input) begin
                    guess_d = bus.Player_Input;
                    state_d = ST_SCORE;
                end else if (!bus.Timeout) begin
                    state_d = ST_REPORT;
                end
            end
            ST_SCORE: begin
                leds_d = result_q;
                if (rounds_q != '1) begin
                    rounds_d = rounds_q + SCORE_W'(1);
                end
                score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                if (!bus.Timeout) begin
                    state_d = ST_REPORT;
                end else begin
                    capture = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_REPORT: begin
                if (bus.Load_Input) begin
                    score_d  = '0;
                    rounds_d = '0;
                    leds_d   = '0;
                    result_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            shift_d   = bus.Digits_In;
            idx_d     = '0;
            bcd_err_d = bad_digit;
        end

        busy_d = (state_d == ST_EVAL);
        req_d  = (state_d == ST_REPORT) && (state_q != ST_REPORT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            score_q   <= '0;
            rounds_q  <= '0;
            leds_q    <= '0;
            result_q  <= '0;
            guess_q   <= '0;
            bcd_err_q <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            score_q   <= score_d;
            rounds_q  <= rounds_d;
            leds_q    <= leds_d;
            result_q  <= result_d;
            guess_q   <= guess_d;
            bcd_err_q <= bcd_err_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.Score     = score_q;
    assign bus.Rounds    = rounds_q;
    assign bus.LEDs      = leds_q;
    assign bus.Score_Req = req_q;
    assign bus.Busy      = busy_q;
    assign bus.Bcd_Err   = bcd_err_q;

endmodule

// File: tb/tb_bcd_div_judge.sv
// Bench for bcd_div_judge: directed scenarios plus randomized games against an integer-arithmetic model.
module tb_bcd_div_judge;

    localparam int unsigned ND   = 4;
    localparam int unsigned NT   = 4;
    localparam int unsigned SW   = 3;
    localparam int          SMAX = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_div_judge_if #(.NUM_DIGITS(ND), .NUM_TESTS(NT), .SCORE_W(SW)) bus ();

    bcd_div_judge #(.NUM_DIGITS(ND), .NUM_TESTS(NT), .SCORE_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int              m_score;
    int              m_rounds;
    logic [NT-1:0]   m_leds;
    logic [4*ND-1:0] cur_op;

    function automatic logic ref_bad(input logic [4*ND-1:0] op);
        logic b;
        b = 1'b0;
        for (int k = 0; k < int'(ND); k++) if (op[4*k +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [NT-1:0] ref_result(input logic [4*ND-1:0] op);
        int divs [4];
        int value;
        int place;
        logic [NT-1:0] r;
        divs  = '{2, 3, 7, 11};
        value = 0;
        place = 1;
        for (int k = 0; k < int'(ND); k++) begin
            value = value + int'(op[4*k +: 4]) * place;
            place = place * 10;
        end
        for (int i = 0; i < int'(NT); i++) r[i] = ((value % divs[i]) == 0);
        return ref_bad(op) ? '0 : r;
    endfunction

    function automatic int ref_inc(input logic [NT-1:0] g, input logic [NT-1:0] r, input logic mode);
        int n;
        if (!mode) return (g == r) ? 1 : 0;
        n = 0;
        for (int i = 0; i < int'(NT); i++) if (g[i] == r[i]) n++;
        return n;
    endfunction

    function automatic logic [4*ND-1:0] rand_op();
        logic [4*ND-1:0] op;
        for (int k = 0; k < int'(ND); k++) op[4*k +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 4) == 0) op[4*$urandom_range(0, ND-1) +: 4] = 4'($urandom_range(10, 15));
        return op;
    endfunction

    task automatic model_clear();
        m_score  = 0;
        m_rounds = 0;
        m_leds   = '0;
    endtask

    task automatic model_score(input logic [NT-1:0] g, input logic mode);
        logic [NT-1:0] r;
        r        = ref_result(cur_op);
        m_leds   = r;
        m_rounds = (m_rounds + 1 > SMAX) ? SMAX : m_rounds + 1;
        m_score  = (m_score + ref_inc(g, r, mode) > SMAX) ? SMAX : m_score + ref_inc(g, r, mode);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic [4*ND-1:0] op);
        bus.Digits_In  = op;
        bus.Game_Start = 1'b1;
        cur_op         = op;
        tick();
        bus.Game_Start = 1'b0;
    endtask

    task automatic eval_to_play();
        repeat (ND) tick();
    endtask

    // Submit from PLAY; the opposite mode is shown during PLAY so only the SCORE-cycle value may count.
    task automatic submit(input logic [NT-1:0] g, input logic mode, input logic [4*ND-1:0] next_op,
                          input logic expire);
        bus.Player_Input = g;
        bus.Load_Input   = 1'b1;
        bus.Partial_Mode = ~mode;
        tick();
        bus.Load_Input   = 1'b0;
        bus.Partial_Mode = mode;
        bus.Digits_In    = next_op;
        bus.Timeout      = ~expire;
        tick();
        bus.Timeout      = 1'b1;
        model_score(g, mode);
        if (!expire) cur_op = next_op;
    endtask

    task automatic return_to_idle();
        bus.Load_Input = 1'b1;
        tick();
        bus.Load_Input = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #2;
        total += 6;
        if (bus.Score !== '0)     begin bad++; $display("FAIL reset_score got=%0d want=0", bus.Score); end
        if (bus.Rounds !== '0)    begin bad++; $display("FAIL reset_rounds got=%0d want=0", bus.Rounds); end
        if (bus.LEDs !== '0)      begin bad++; $display("FAIL reset_leds got=%b want=0", bus.LEDs); end
        if (bus.Score_Req !== 0)  begin bad++; $display("FAIL reset_req got=%b want=0", bus.Score_Req); end
        if (bus.Busy !== 0)       begin bad++; $display("FAIL reset_busy got=%b want=0", bus.Busy); end
        if (bus.Bcd_Err !== 0)    begin bad++; $display("FAIL reset_bcderr got=%b want=0", bus.Bcd_Err); end
        @(posedge clk);
        #1 reset = 1'b1;
        model_clear();
        tick();
    endtask

    task automatic test_exact_84();
        start_game(16'h0084);
        for (int k = 0; k < int'(ND); k++) begin
            total++;
            if (bus.Busy !== 1'b1) begin bad++; $display("FAIL eval_busy cyc=%0d got=%b want=1", k, bus.Busy); end
            tick();
        end
        total += 2;
        if (bus.Busy !== 1'b0)    begin bad++; $display("FAIL play_latency busy got=%b want=0", bus.Busy); end
        if (bus.Bcd_Err !== 1'b0) begin bad++; $display("FAIL op84_bcderr got=%b want=0", bus.Bcd_Err); end
        submit(4'b0111, 1'b0, 16'h0077, 1'b0);
        total += 4;
        if (bus.Score !== SW'(m_score))   begin bad++; $display("FAIL op84_score got=%0d want=%0d", bus.Score, m_score); end
        if (bus.Rounds !== SW'(m_rounds)) begin bad++; $display("FAIL op84_rounds got=%0d want=%0d", bus.Rounds, m_rounds); end
        if (bus.LEDs !== m_leds)          begin bad++; $display("FAIL op84_leds got=%b want=%b", bus.LEDs, m_leds); end
        if (bus.Busy !== 1'b1)            begin bad++; $display("FAIL op84_recapture busy got=%b want=1", bus.Busy); end
    endtask

    task automatic test_partial_77();
        eval_to_play();
        submit(4'b1000, 1'b1, 16'h0077, 1'b0);
        total += 2;
        if (bus.Score !== SW'(m_score)) begin bad++; $display("FAIL op77_partial_score got=%0d want=%0d", bus.Score, m_score); end
        if (bus.LEDs !== m_leds)        begin bad++; $display("FAIL op77_leds got=%b want=%b", bus.LEDs, m_leds); end
        eval_to_play();
        submit(4'b1000, 1'b0, 16'h0084, 1'b0);
        total += 2;
        if (bus.Score !== SW'(m_score))   begin bad++; $display("FAIL op77_exact_score got=%0d want=%0d", bus.Score, m_score); end
        if (bus.Rounds !== SW'(m_rounds)) begin bad++; $display("FAIL op77_rounds got=%0d want=%0d", bus.Rounds, m_rounds); end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 8; n++) begin
            eval_to_play();
            submit(ref_result(cur_op), 1'b1, rand_op(), (n == 7));
            total += 2;
            if (bus.Score !== SW'(m_score))   begin bad++; $display("FAIL sat_score rnd=%0d got=%0d want=%0d", n, bus.Score, m_score); end
            if (bus.Rounds !== SW'(m_rounds)) begin bad++; $display("FAIL sat_rounds rnd=%0d got=%0d want=%0d", n, bus.Rounds, m_rounds); end
        end
        total += 3;
        if (bus.Score !== SW'(SMAX))  begin bad++; $display("FAIL sat_final_score got=%0d want=%0d", bus.Score, SMAX); end
        if (bus.Rounds !== SW'(SMAX)) begin bad++; $display("FAIL sat_final_rounds got=%0d want=%0d", bus.Rounds, SMAX); end
        if (bus.Score_Req !== 1'b1)   begin bad++; $display("FAIL sat_report_req got=%b want=1", bus.Score_Req); end
        return_to_idle();
        total += 3;
        if (bus.Score !== '0)  begin bad++; $display("FAIL idle_score got=%0d want=0", bus.Score); end
        if (bus.Rounds !== '0) begin bad++; $display("FAIL idle_rounds got=%0d want=0", bus.Rounds); end
        if (bus.LEDs !== '0)   begin bad++; $display("FAIL idle_leds got=%b want=0", bus.LEDs); end
    endtask

    task automatic test_bcd_err();
        start_game(16'h00A4);
        total++;
        if (bus.Bcd_Err !== 1'b1) begin bad++; $display("FAIL bcderr_capture got=%b want=1", bus.Bcd_Err); end
        eval_to_play();
        total++;
        if (bus.Bcd_Err !== 1'b1) begin bad++; $display("FAIL bcderr_play got=%b want=1", bus.Bcd_Err); end
        submit(4'b0000, 1'b0, 16'h0084, 1'b0);
        total += 3;
        if (bus.Score !== SW'(m_score)) begin bad++; $display("FAIL bcderr_score got=%0d want=%0d", bus.Score, m_score); end
        if (bus.LEDs !== m_leds)        begin bad++; $display("FAIL bcderr_leds got=%b want=%b", bus.LEDs, m_leds); end
        if (bus.Bcd_Err !== 1'b0)       begin bad++; $display("FAIL bcderr_clear got=%b want=0", bus.Bcd_Err); end
        eval_to_play();
    endtask

    task automatic test_load_and_timeout();
        bus.Player_Input = ref_result(cur_op);
        bus.Load_Input   = 1'b1;
        bus.Timeout      = 1'b0;
        bus.Partial_Mode = 1'b0;
        tick();
        bus.Load_Input = 1'b0;
        tick();
        model_score(ref_result(cur_op), 1'b0);
        total += 2;
        if (bus.Score !== SW'(m_score)) begin bad++; $display("FAIL lt_score got=%0d want=%0d", bus.Score, m_score); end
        if (bus.Score_Req !== 1'b1)     begin bad++; $display("FAIL lt_req_first got=%b want=1", bus.Score_Req); end
        for (int k = 0; k < 2; k++) begin
            tick();
            total += 2;
            if (bus.Score_Req !== 1'b0)     begin bad++; $display("FAIL lt_req_held cyc=%0d got=%b want=0", k, bus.Score_Req); end
            if (bus.Score !== SW'(m_score)) begin bad++; $display("FAIL lt_score_held got=%0d want=%0d", bus.Score, m_score); end
        end
        bus.Timeout = 1'b1;
        return_to_idle();
        total++;
        if (bus.Score !== '0) begin bad++; $display("FAIL lt_idle_score got=%0d want=0", bus.Score); end
    endtask

    task automatic test_timeout_eval();
        start_game(16'h1234);
        tick();
        bus.Timeout = 1'b0;
        tick();
        bus.Timeout = 1'b1;
        total += 2;
        if (bus.Score_Req !== 1'b1) begin bad++; $display("FAIL eval_timeout_req got=%b want=1", bus.Score_Req); end
        if (bus.Busy !== 1'b0)      begin bad++; $display("FAIL eval_timeout_busy got=%b want=0", bus.Busy); end
        return_to_idle();
    endtask

    task automatic test_random();
        for (int game = 0; game < 8; game++) begin
            int nr;
            nr = $urandom_range(1, 3);
            start_game(rand_op());
            for (int r = 0; r < nr; r++) begin
                logic [NT-1:0] g;
                logic          mode;
                eval_to_play();
                total++;
                if (bus.Bcd_Err !== ref_bad(cur_op)) begin bad++; $display("FAIL rnd_bcderr op=%h got=%b want=%b", cur_op, bus.Bcd_Err, ref_bad(cur_op)); end
                g    = ($urandom_range(0, 2) == 0) ? ref_result(cur_op) : NT'($urandom);
                mode = 1'($urandom);
                submit(g, mode, rand_op(), (r == nr - 1));
                total += 3;
                if (bus.Score !== SW'(m_score))   begin bad++; $display("FAIL rnd_score g=%0d got=%0d want=%0d", game, bus.Score, m_score); end
                if (bus.Rounds !== SW'(m_rounds)) begin bad++; $display("FAIL rnd_rounds g=%0d got=%0d want=%0d", game, bus.Rounds, m_rounds); end
                if (bus.LEDs !== m_leds)          begin bad++; $display("FAIL rnd_leds g=%0d got=%b want=%b", game, bus.LEDs, m_leds); end
            end
            total++;
            if (bus.Score_Req !== 1'b1) begin bad++; $display("FAIL rnd_report_req g=%0d got=%b want=1", game, bus.Score_Req); end
            return_to_idle();
        end
    endtask

    task automatic test_reset_mid_eval();
        start_game(16'h0084);
        eval_to_play();
        submit(4'b0111, 1'b0, 16'h0B12, 1'b0);
        total += 2;
        if (bus.Score !== SW'(m_score)) begin bad++; $display("FAIL pre_reset_score got=%0d want=%0d", bus.Score, m_score); end
        if (bus.Bcd_Err !== 1'b1)       begin bad++; $display("FAIL pre_reset_bcderr got=%b want=1", bus.Bcd_Err); end
        tick();
        tick();
        #2 reset = 1'b0;
        #2;
        total += 5;
        if (bus.Score !== '0)  begin bad++; $display("FAIL mid_reset_score got=%0d want=0", bus.Score); end
        if (bus.Rounds !== '0) begin bad++; $display("FAIL mid_reset_rounds got=%0d want=0", bus.Rounds); end
        if (bus.LEDs !== '0)   begin bad++; $display("FAIL mid_reset_leds got=%b want=0", bus.LEDs); end
        if (bus.Busy !== 0)    begin bad++; $display("FAIL mid_reset_busy got=%b want=0", bus.Busy); end
        if (bus.Bcd_Err !== 0) begin bad++; $display("FAIL mid_reset_bcderr got=%b want=0", bus.Bcd_Err); end
        @(posedge clk);
        #1 reset = 1'b1;
        model_clear();
        tick();
        start_game(16'h0084);
        for (int k = 0; k < int'(ND); k++) begin
            total++;
            if (bus.Busy !== 1'b1) begin bad++; $display("FAIL rst_eval_busy cyc=%0d got=%b want=1", k, bus.Busy); end
            tick();
        end
        total++;
        if (bus.Busy !== 1'b0) begin bad++; $display("FAIL rst_play_busy got=%b want=0", bus.Busy); end
        submit(4'b0111, 1'b0, 16'h0000, 1'b1);
        total += 2;
        if (bus.Score !== SW'(m_score)) begin bad++; $display("FAIL rst_rerun_score got=%0d want=%0d", bus.Score, m_score); end
        if (bus.LEDs !== m_leds)        begin bad++; $display("FAIL rst_rerun_leds got=%b want=%b", bus.LEDs, m_leds); end
        return_to_idle();
    endtask

    initial begin
        bus.Digits_In    = '0;
        bus.Game_Start   = 1'b0;
        bus.Load_Input   = 1'b0;
        bus.Timeout      = 1'b1;
        bus.Player_Input = '0;
        bus.Partial_Mode = 1'b0;
        cur_op           = '0;
        model_clear();
        test_reset();
        test_exact_84();
        test_partial_77();
        test_saturation();
        test_bcd_err();
        test_load_and_timeout();
        test_timeout_eval();
        test_random();
        test_reset_mid_eval();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
